serial_uart_bridge: RTL and testbench
=====================================

Name: serial_uart_bridge

Overview:
- Device end of the processor's byte-serial IO port; the processor's data memory drives the other end.
- Accepts bytes the processor writes (serial_out / serial_wren_out), buffers them, and transmits them as 8N1 UART frames.
- Receives 8N1 frames, buffers them, and presents them to the processor (serial_in / serial_valid_in, consumed by serial_rden_out).
- Sits at top level between the processor and the board UART pins.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); must be >= 4.
- FIFO_DEPTH, 16, entries in each of the TX and RX FIFOs; power of two, >= 2.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_wdata_in  in  8  byte from processor serial_out.
- cpu_wren_in  in  1  processor serial_wren_out; one-cycle write strobe.
- cpu_ready_out  out  1  to processor serial_ready_in; TX FIFO can accept a byte.
- cpu_rdata_out  out  8  to processor serial_in; head of RX FIFO.
- cpu_valid_out  out  1  to processor serial_valid_in; RX FIFO non-empty.
- cpu_rden_in  in  1  processor serial_rden_out; one-cycle consume strobe.
- uart_rx_in  in  1  asynchronous UART receive line; idle high.
- uart_tx_out  out  1  UART transmit line, registered; idle high.
- err_clear_in  in  1  clears the sticky error flags.
- rx_overrun_out  out  1  sticky flag: received byte dropped because the RX FIFO was full.
- rx_frame_err_out  out  1  sticky flag: stop bit sampled low.

Behaviour:
- Clock and reset: one clock, "clock". Reset is synchronous and active-high, named "reset".
- Reset values: uart_tx_out=1, cpu_ready_out=1, cpu_valid_out=0, cpu_rdata_out=0, both error flags 0, both FIFOs empty, both FSMs in IDLE.
- Reset mid-frame aborts the frame; uart_tx_out is high after the reset edge.

Write side:
- A write is accepted when cpu_wren_in=1 and cpu_ready_out=1 at the rising edge.
- cpu_ready_out = !tx_full.
- cpu_wren_in while full is ignored: no state change, no error.

TX FSM (IDLE, START, DATA, STOP):
- IDLE, FIFO non-empty: pop into the shift register, go to START; uart_tx_out=0 from that edge.
- A write at edge N therefore drives the start bit from edge N+1 when the FSM is in IDLE.
- START: CLKS_PER_BIT cycles, then DATA.
- DATA: 8 bits LSB first, CLKS_PER_BIT cycles each, 3-bit index, then STOP.
- STOP: uart_tx_out=1 for CLKS_PER_BIT cycles, then IDLE.
- Back-to-back frames are permitted: STOP -> IDLE -> START adds exactly one cycle between frames.

RX path:
- uart_rx_in passes through a 2-flop synchronizer.
- IDLE: a synchronized low moves to START and loads the counter with CLKS_PER_BIT/2.
- START: at mid-bit, if the line is high it is a false start -> IDLE; otherwise go to DATA.
- DATA: sample every CLKS_PER_BIT cycles at bit centres; 8 bits LSB first.
- STOP: sample at mid-bit.
  - High: push the byte into the RX FIFO, or set rx_overrun_out if the FIFO is full.
  - Low: discard the byte and set rx_frame_err_out.
  - Both cases return to IDLE immediately after the sample.

Read side:
- cpu_valid_out = !rx_empty.
- cpu_rdata_out = RX FIFO head (show-ahead).
- Pop on cpu_rden_in && cpu_valid_out; cpu_rden_in while empty is ignored.
- cpu_valid_out drops the cycle after the last pop.

FIFO rules:
- Full and empty are evaluated before the edge.
- A push to a full FIFO is dropped even if a pop occurs the same cycle.
- A simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- Pointers wrap modulo FIFO_DEPTH; the count register is log2(FIFO_DEPTH)+1 bits wide.

Error flags:
- Sticky until err_clear_in.
- If a set and err_clear_in occur in the same cycle, the set wins.

Decomposition:
- Package serial_uart_pkg holds:
  - TX and RX state encodings (2 bits each).
  - DATA_BITS=8.
  - IDLE_LEVEL=1'b1.
- Sub-module sync_fifo (parameters WIDTH, DEPTH) provides the show-ahead FIFO with full, empty, push and pop. It is instantiated twice, once for TX and once for RX.

Test Plan:
All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=16.
- Reset: assert reset for 2 cycles mid-TX-frame -> uart_tx_out=1, cpu_ready_out=1, cpu_valid_out=0, flags=0 on the next edge.
- TX single byte: write 0x55 -> uart_tx_out holds each of 0,1,0,1,0,1,0,1,0,1 for exactly 4 cycles, then stays 1.
- TX backpressure: write 0x00..0x11 on 18 consecutive cycles -> 17 bytes accepted, cpu_ready_out=0 after the 17th write, 0x11 ignored; 17 frames 0x00..0x10 emitted in order.
- RX normal: drive a frame of 0xA3 -> cpu_valid_out=1 with cpu_rdata_out=0xA3 after the stop-bit sample; pulse cpu_rden_in -> cpu_valid_out=0 the next cycle.
- RX errors:
  - Stop bit 0 -> no push, rx_frame_err_out=1.
  - Then 17 frames 0x01..0x11 with no reads -> 16 stored, rx_overrun_out=1, head=0x01.
  - err_clear_in -> both flags 0.
- RX glitch: a 1-cycle low pulse on uart_rx_in -> false start, no push, no error flags, the FSM accepts the next valid frame correctly.

Source files
------------

// File: rtl/serial_uart_pkg.sv
// Shared encodings and constants for the byte-serial UART bridge.
package serial_uart_pkg;

  localparam int unsigned DATA_BITS  = 8;
  localparam logic        IDLE_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    TxIdle  = 2'd0,
    TxStart = 2'd1,
    TxData  = 2'd2,
    TxStop  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    RxIdle  = 2'd0,
    RxStart = 2'd1,
    RxData  = 2'd2,
    RxStop  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/serial_uart_bridge_if.sv
// Processor-side byte port: write strobe/ready and show-ahead read data/valid/consume.
interface serial_uart_bridge_if;
  import serial_uart_pkg::*;

  logic [DATA_BITS-1:0] cpu_wdata_in;
  logic                 cpu_wren_in;
  logic                 cpu_ready_out;
  logic [DATA_BITS-1:0] cpu_rdata_out;
  logic                 cpu_valid_out;
  logic                 cpu_rden_in;

  modport master (
    output cpu_wdata_in, cpu_wren_in, cpu_rden_in,
    input  cpu_ready_out, cpu_rdata_out, cpu_valid_out
  );

  modport slave (
    input  cpu_wdata_in, cpu_wren_in, cpu_rden_in,
    output cpu_ready_out, cpu_rdata_out, cpu_valid_out
  );

endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; pushes when full and pops when empty are ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [CntW-1:0]  r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CntW'(DEPTH));
  assign o_empty   = (r_count == '0);
  // Full/empty are pre-edge values, so a push to a full FIFO drops even with a pop.
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_rdata   = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clock) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/serial_uart_bridge.sv
// Buffered 8N1 UART between the processor byte port and the board pins,
// with sticky RX overrun and framing-error flags.
module serial_uart_bridge
  import serial_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  serial_uart_bridge_if.slave  cpu,
  input  logic                 uart_rx_in,
  output logic                 uart_tx_out,
  input  logic                 err_clear_in,
  output logic                 rx_overrun_out,
  output logic                 rx_frame_err_out
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW = $clog2(DATA_BITS);
  localparam logic [CntW-1:0] BitLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfBit = CntW'(CLKS_PER_BIT / 2);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_BITS - 1);

  logic                 w_tx_full;
  logic                 w_tx_empty;
  logic [DATA_BITS-1:0] w_tx_rdata;
  logic                 w_tx_pop;
  logic                 w_rx_full;
  logic                 w_rx_empty;
  logic                 w_rx_push;

  tx_state_e            r_tx_state, w_tx_state_d;
  logic [CntW-1:0]      r_tx_cnt, w_tx_cnt_d;
  logic [IdxW-1:0]      r_tx_idx, w_tx_idx_d;
  logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift_d;
  logic                 r_tx_line, w_tx_line_d;

  rx_state_e            r_rx_state, w_rx_state_d;
  logic [CntW-1:0]      r_rx_cnt, w_rx_cnt_d;
  logic [IdxW-1:0]      r_rx_idx, w_rx_idx_d;
  logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift_d;
  logic                 r_rx_meta, r_rx_sync;
  logic                 w_ovr_set, w_ferr_set;
  logic                 r_overrun, r_frame_err;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (cpu.cpu_wren_in),
    .i_pop   (w_tx_pop),
    .i_wdata (cpu.cpu_wdata_in),
    .o_rdata (w_tx_rdata),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_rx_push),
    .i_pop   (cpu.cpu_rden_in),
    .i_wdata (r_rx_shift),
    .o_rdata (cpu.cpu_rdata_out),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

  assign cpu.cpu_ready_out = !w_tx_full;
  assign cpu.cpu_valid_out = !w_rx_empty;
  assign uart_tx_out       = r_tx_line;
  assign rx_overrun_out    = r_overrun;
  assign rx_frame_err_out  = r_frame_err;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_tx_state <= TxIdle;
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_shift <= '0;
      r_tx_line  <= IDLE_LEVEL;
    end else begin
      r_tx_state <= w_tx_state_d;
      r_tx_cnt   <= w_tx_cnt_d;
      r_tx_idx   <= w_tx_idx_d;
      r_tx_shift <= w_tx_shift_d;
      r_tx_line  <= w_tx_line_d;
    end
  end

  // The line is registered, so each bit level is loaded on the edge that begins its period.
  always_comb begin
    w_tx_state_d = r_tx_state;
    w_tx_cnt_d   = r_tx_cnt;
    w_tx_idx_d   = r_tx_idx;
    w_tx_shift_d = r_tx_shift;
    w_tx_line_d  = r_tx_line;
    w_tx_pop     = 1'b0;
    unique case (r_tx_state)
      TxIdle: begin
        w_tx_line_d = IDLE_LEVEL;
        if (!w_tx_empty) begin
          w_tx_pop     = 1'b1;
          w_tx_shift_d = w_tx_rdata;
          w_tx_cnt_d   = '0;
          w_tx_idx_d   = '0;
          w_tx_line_d  = 1'b0;
          w_tx_state_d = TxStart;
        end
      end
      TxStart: begin
        if (r_tx_cnt == BitLast) begin
          w_tx_cnt_d   = '0;
          w_tx_line_d  = r_tx_shift[0];
          w_tx_shift_d = {1'b0, r_tx_shift[DATA_BITS-1:1]};
          w_tx_state_d = TxData;
        end else begin
          w_tx_cnt_d = r_tx_cnt + CntW'(1);
        end
      end
      TxData: begin
        if (r_tx_cnt == BitLast) begin
          w_tx_cnt_d = '0;
          if (r_tx_idx == IdxLast) begin
            w_tx_line_d  = IDLE_LEVEL;
            w_tx_state_d = TxStop;
          end else begin
            w_tx_idx_d   = r_tx_idx + IdxW'(1);
            w_tx_line_d  = r_tx_shift[0];
            w_tx_shift_d = {1'b0, r_tx_shift[DATA_BITS-1:1]};
          end
        end else begin
          w_tx_cnt_d = r_tx_cnt + CntW'(1);
        end
      end
      TxStop: begin
        if (r_tx_cnt == BitLast) begin
          w_tx_cnt_d   = '0;
          w_tx_state_d = TxIdle;
        end else begin
          w_tx_cnt_d = r_tx_cnt + CntW'(1);
        end
      end
      default: w_tx_state_d = TxIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rx_meta  <= IDLE_LEVEL;
      r_rx_sync  <= IDLE_LEVEL;
      r_rx_state <= RxIdle;
      r_rx_cnt   <= '0;
      r_rx_idx   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_meta  <= uart_rx_in;
      r_rx_sync  <= r_rx_meta;
      r_rx_state <= w_rx_state_d;
      r_rx_cnt   <= w_rx_cnt_d;
      r_rx_idx   <= w_rx_idx_d;
      r_rx_shift <= w_rx_shift_d;
    end
  end

  // Down-counter: half a bit to reach the start-bit centre, then a full bit per sample.
  always_comb begin
    w_rx_state_d = r_rx_state;
    w_rx_cnt_d   = r_rx_cnt;
    w_rx_idx_d   = r_rx_idx;
    w_rx_shift_d = r_rx_shift;
    w_rx_push    = 1'b0;
    w_ovr_set    = 1'b0;
    w_ferr_set   = 1'b0;
    unique case (r_rx_state)
      RxIdle: begin
        if (!r_rx_sync) begin
          w_rx_cnt_d   = HalfBit;
          w_rx_state_d = RxStart;
        end
      end
      RxStart: begin
        if (r_rx_cnt == '0) begin
          if (r_rx_sync) begin
            w_rx_state_d = RxIdle;
          end else begin
            w_rx_cnt_d   = BitLast;
            w_rx_idx_d   = '0;
            w_rx_state_d = RxData;
          end
        end else begin
          w_rx_cnt_d = r_rx_cnt - CntW'(1);
        end
      end
      RxData: begin
        if (r_rx_cnt == '0) begin
          w_rx_shift_d = {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
          w_rx_cnt_d   = BitLast;
          if (r_rx_idx == IdxLast) begin
            w_rx_state_d = RxStop;
          end else begin
            w_rx_idx_d = r_rx_idx + IdxW'(1);
          end
        end else begin
          w_rx_cnt_d = r_rx_cnt - CntW'(1);
        end
      end
      RxStop: begin
        if (r_rx_cnt == '0) begin
          w_rx_state_d = RxIdle;
          if (r_rx_sync) begin
            w_rx_push = 1'b1;
            w_ovr_set = w_rx_full;
          end else begin
            w_ferr_set = 1'b1;
          end
        end else begin
          w_rx_cnt_d = r_rx_cnt - CntW'(1);
        end
      end
      default: w_rx_state_d = RxIdle;
    endcase
  end

  // Sticky flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_ovr_set) begin
        r_overrun <= 1'b1;
      end else if (err_clear_in) begin
        r_overrun <= 1'b0;
      end
      if (w_ferr_set) begin
        r_frame_err <= 1'b1;
      end else if (err_clear_in) begin
        r_frame_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_uart_bridge.sv
// Directed bench for serial_uart_bridge at CLKS_PER_BIT=4, FIFO_DEPTH=16.
module tb_serial_uart_bridge;

  localparam int CPB   = 4;
  localparam int DEPTH = 16;

  logic clock = 1'b0;
  logic reset;
  logic uart_rx_in;
  logic uart_tx_out;
  logic err_clear_in;
  logic rx_overrun_out;
  logic rx_frame_err_out;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  serial_uart_bridge_if cpu_if ();

  serial_uart_bridge #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .cpu              (cpu_if),
    .uart_rx_in       (uart_rx_in),
    .uart_tx_out      (uart_tx_out),
    .err_clear_in     (err_clear_in),
    .rx_overrun_out   (rx_overrun_out),
    .rx_frame_err_out (rx_frame_err_out)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Drives one 8N1 frame at negedges, then idles high for two bit times.
  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    @(negedge clock);
    uart_rx_in = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      uart_rx_in = b[i];
      repeat (CPB) @(negedge clock);
    end
    uart_rx_in = stop_bit;
    repeat (CPB) @(negedge clock);
    uart_rx_in = 1'b1;
    repeat (2 * CPB) @(negedge clock);
  endtask

  task automatic test_reset();
    int lows;
    reset = 1'b1;
    uart_rx_in = 1'b1;
    err_clear_in = 1'b0;
    cpu_if.cpu_wren_in = 1'b0;
    cpu_if.cpu_rden_in = 1'b0;
    cpu_if.cpu_wdata_in = 8'h00;
    repeat (3) @(posedge clock);
    @(negedge clock) reset = 1'b0;
    n_checks++; if (uart_tx_out !== 1'b1) $display("FAIL rst_tx got %b exp 1", uart_tx_out); else n_pass++;
    n_checks++; if (cpu_if.cpu_ready_out !== 1'b1) $display("FAIL rst_ready got %b exp 1", cpu_if.cpu_ready_out); else n_pass++;
    n_checks++; if (cpu_if.cpu_valid_out !== 1'b0) $display("FAIL rst_valid got %b exp 0", cpu_if.cpu_valid_out); else n_pass++;
    n_checks++; if (cpu_if.cpu_rdata_out !== 8'h00) $display("FAIL rst_rdata got %h exp 00", cpu_if.cpu_rdata_out); else n_pass++;
    n_checks++; if ({rx_overrun_out, rx_frame_err_out} !== 2'b00) $display("FAIL rst_flags got %b exp 00", {rx_overrun_out, rx_frame_err_out}); else n_pass++;
    // Start a frame, then reset it mid-flight while the line is low.
    cpu_if.cpu_wdata_in = 8'h00;
    cpu_if.cpu_wren_in = 1'b1;
    @(negedge clock) cpu_if.cpu_wren_in = 1'b0;
    repeat (10) @(negedge clock);
    n_checks++; if (uart_tx_out !== 1'b0) $display("FAIL midframe_tx got %b exp 0", uart_tx_out); else n_pass++;
    reset = 1'b1;
    @(negedge clock);
    n_checks++; if (uart_tx_out !== 1'b1) $display("FAIL rst_edge_tx got %b exp 1", uart_tx_out); else n_pass++;
    @(negedge clock) reset = 1'b0;
    n_checks++; if (cpu_if.cpu_ready_out !== 1'b1) $display("FAIL rst2_ready got %b exp 1", cpu_if.cpu_ready_out); else n_pass++;
    n_checks++; if (cpu_if.cpu_valid_out !== 1'b0) $display("FAIL rst2_valid got %b exp 0", cpu_if.cpu_valid_out); else n_pass++;
    n_checks++; if ({rx_overrun_out, rx_frame_err_out} !== 2'b00) $display("FAIL rst2_flags got %b exp 00", {rx_overrun_out, rx_frame_err_out}); else n_pass++;
    lows = 0;
    repeat (60) begin
      @(negedge clock);
      if (uart_tx_out !== 1'b1) lows++;
    end
    n_checks++; if (lows !== 0) $display("FAIL rst_abort_lowcycles got %0d exp 0", lows); else n_pass++;
  endtask

  task automatic test_tx_single();
    logic [9:0] frame;
    int bad;
    frame = {1'b1, 8'h55, 1'b0};
    @(negedge clock);
    cpu_if.cpu_wdata_in = 8'h55;
    cpu_if.cpu_wren_in = 1'b1;
    @(negedge clock) cpu_if.cpu_wren_in = 1'b0;
    n_checks++; if (uart_tx_out !== 1'b1) $display("FAIL tx_pre_start got %b exp 1", uart_tx_out); else n_pass++;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      n_checks++;
      if (uart_tx_out !== frame[i/4]) $display("FAIL tx55_cycle%0d got %b exp %b", i, uart_tx_out, frame[i/4]);
      else n_pass++;
    end
    bad = 0;
    repeat (12) begin
      @(negedge clock);
      if (uart_tx_out !== 1'b1) bad++;
    end
    n_checks++; if (bad !== 0) $display("FAIL tx_after_idle lowcycles got %0d exp 0", bad); else n_pass++;
  endtask

  task automatic test_tx_backpressure();
    logic [7:0] got [17];
    logic       stop_ok [17];
    int         start_cyc [17];
    int         lows;
    for (int f = 0; f < 17; f++) begin
      got[f] = 8'hFF;
      stop_ok[f] = 1'b0;
      start_cyc[f] = 0;
    end
    fork
      begin
        for (int i = 0; i < 18; i++) begin
          @(negedge clock);
          n_checks++;
          if (cpu_if.cpu_ready_out !== (i < 17)) $display("FAIL bp_ready_before_wr%0d got %b exp %b", i, cpu_if.cpu_ready_out, (i < 17));
          else n_pass++;
          cpu_if.cpu_wdata_in = 8'(i);
          cpu_if.cpu_wren_in = 1'b1;
        end
        @(negedge clock) cpu_if.cpu_wren_in = 1'b0;
        n_checks++; if (cpu_if.cpu_ready_out !== 1'b0) $display("FAIL bp_ready_after got %b exp 0", cpu_if.cpu_ready_out); else n_pass++;
      end
      begin
        for (int f = 0; f < 17; f++) begin
          int t;
          t = 0;
          while (uart_tx_out !== 1'b0 && t < 300) begin
            @(negedge clock);
            t++;
          end
          if (t >= 300) begin
            n_checks++;
            $display("FAIL bp_frame%0d_timeout waited %0d cycles exp start bit", f, t);
            break;
          end
          start_cyc[f] = cyc;
          repeat (6) @(negedge clock);
          for (int b = 0; b < 8; b++) begin
            got[f][b] = uart_tx_out;
            repeat (4) @(negedge clock);
          end
          stop_ok[f] = uart_tx_out;
        end
      end
    join
    for (int f = 0; f < 17; f++) begin
      n_checks++;
      if (got[f] !== 8'(f) || stop_ok[f] !== 1'b1)
        $display("FAIL bp_frame%0d got %h stop %b exp %h stop 1", f, got[f], stop_ok[f], 8'(f));
      else n_pass++;
    end
    for (int f = 1; f < 17; f++) begin
      n_checks++;
      if (start_cyc[f] - start_cyc[f-1] !== 41)
        $display("FAIL bp_gap%0d got %0d cycles exp 41", f, start_cyc[f] - start_cyc[f-1]);
      else n_pass++;
    end
    lows = 0;
    repeat (100) begin
      @(negedge clock);
      if (uart_tx_out !== 1'b1) lows++;
    end
    n_checks++; if (lows !== 0) $display("FAIL bp_no_extra_frame lowcycles got %0d exp 0", lows); else n_pass++;
  endtask

  task automatic test_rx_normal();
    send_rx(8'hA3, 1'b1);
    n_checks++; if (cpu_if.cpu_valid_out !== 1'b1) $display("FAIL rx_valid got %b exp 1", cpu_if.cpu_valid_out); else n_pass++;
    n_checks++; if (cpu_if.cpu_rdata_out !== 8'hA3) $display("FAIL rx_data got %h exp a3", cpu_if.cpu_rdata_out); else n_pass++;
    n_checks++; if ({rx_overrun_out, rx_frame_err_out} !== 2'b00) $display("FAIL rx_flags got %b exp 00", {rx_overrun_out, rx_frame_err_out}); else n_pass++;
    cpu_if.cpu_rden_in = 1'b1;
    @(negedge clock) cpu_if.cpu_rden_in = 1'b0;
    n_checks++; if (cpu_if.cpu_valid_out !== 1'b0) $display("FAIL rx_valid_after_pop got %b exp 0", cpu_if.cpu_valid_out); else n_pass++;
    n_checks++; if (cpu_if.cpu_rdata_out !== 8'h00) $display("FAIL rx_rdata_empty got %h exp 00", cpu_if.cpu_rdata_out); else n_pass++;
    cpu_if.cpu_rden_in = 1'b1;
    @(negedge clock) cpu_if.cpu_rden_in = 1'b0;
    n_checks++; if (cpu_if.cpu_valid_out !== 1'b0) $display("FAIL rx_pop_empty_valid got %b exp 0", cpu_if.cpu_valid_out); else n_pass++;
  endtask

  task automatic test_rx_errors();
    send_rx(8'h5A, 1'b0);
    n_checks++; if (cpu_if.cpu_valid_out !== 1'b0) $display("FAIL ferr_valid got %b exp 0", cpu_if.cpu_valid_out); else n_pass++;
    n_checks++; if (rx_frame_err_out !== 1'b1) $display("FAIL ferr_flag got %b exp 1", rx_frame_err_out); else n_pass++;
    n_checks++; if (rx_overrun_out !== 1'b0) $display("FAIL ferr_ovr got %b exp 0", rx_overrun_out); else n_pass++;
    for (int i = 1; i <= 17; i++) begin
      send_rx(8'(i), 1'b1);
      if (i == 16) begin
        n_checks++; if (rx_overrun_out !== 1'b0) $display("FAIL ovr_early got %b exp 0", rx_overrun_out); else n_pass++;
      end
    end
    n_checks++; if (cpu_if.cpu_valid_out !== 1'b1) $display("FAIL ovr_valid got %b exp 1", cpu_if.cpu_valid_out); else n_pass++;
    n_checks++; if (cpu_if.cpu_rdata_out !== 8'h01) $display("FAIL ovr_head got %h exp 01", cpu_if.cpu_rdata_out); else n_pass++;
    n_checks++; if (rx_overrun_out !== 1'b1) $display("FAIL ovr_flag got %b exp 1", rx_overrun_out); else n_pass++;
    n_checks++; if (rx_frame_err_out !== 1'b1) $display("FAIL ferr_sticky got %b exp 1", rx_frame_err_out); else n_pass++;
    err_clear_in = 1'b1;
    @(negedge clock) err_clear_in = 1'b0;
    n_checks++; if ({rx_overrun_out, rx_frame_err_out} !== 2'b00) $display("FAIL clear_flags got %b exp 00", {rx_overrun_out, rx_frame_err_out}); else n_pass++;
    for (int i = 1; i <= 16; i++) begin
      n_checks++;
      if (cpu_if.cpu_valid_out !== 1'b1 || cpu_if.cpu_rdata_out !== 8'(i))
        $display("FAIL drain%0d got v%b %h exp v1 %h", i, cpu_if.cpu_valid_out, cpu_if.cpu_rdata_out, 8'(i));
      else n_pass++;
      cpu_if.cpu_rden_in = 1'b1;
      @(negedge clock) cpu_if.cpu_rden_in = 1'b0;
    end
    n_checks++; if (cpu_if.cpu_valid_out !== 1'b0) $display("FAIL drain_empty got %b exp 0", cpu_if.cpu_valid_out); else n_pass++;
  endtask

  task automatic test_rx_glitch();
    @(negedge clock) uart_rx_in = 1'b0;
    @(negedge clock) uart_rx_in = 1'b1;
    repeat (20) @(negedge clock);
    n_checks++; if (cpu_if.cpu_valid_out !== 1'b0) $display("FAIL glitch_valid got %b exp 0", cpu_if.cpu_valid_out); else n_pass++;
    n_checks++; if ({rx_overrun_out, rx_frame_err_out} !== 2'b00) $display("FAIL glitch_flags got %b exp 00", {rx_overrun_out, rx_frame_err_out}); else n_pass++;
    send_rx(8'hC6, 1'b1);
    n_checks++; if (cpu_if.cpu_valid_out !== 1'b1 || cpu_if.cpu_rdata_out !== 8'hC6)
      $display("FAIL glitch_next_frame got v%b %h exp v1 c6", cpu_if.cpu_valid_out, cpu_if.cpu_rdata_out);
    else n_pass++;
    cpu_if.cpu_rden_in = 1'b1;
    @(negedge clock) cpu_if.cpu_rden_in = 1'b0;
    n_checks++; if (cpu_if.cpu_valid_out !== 1'b0) $display("FAIL glitch_pop got %b exp 0", cpu_if.cpu_valid_out); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_tx_single();
    test_tx_backpressure();
    test_rx_normal();
    test_rx_errors();
    test_rx_glitch();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout after %0d cycles", cyc);
    $fatal(1);
  end

endmodule
